// File: rtl/apb_master_mc_if.sv
// rtl/apb_master_mc_if.sv - command port and APB bus bundle for apb_master_mc
interface apb_master_mc_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4
);
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic                         cmd_write;
    logic [ADDR_W-1:0]            cmd_addr;
    logic [DATA_W-1:0]            cmd_wdata;
    logic                         rsp_valid;
    logic [DATA_W-1:0]            rsp_rdata;
    logic                         rsp_err;
    logic [NUM_SLAVES-1:0]        PSEL;
    logic                         PENABLE;
    logic                         PWRITE;
    logic [ADDR_W-1:0]            PADDR;
    logic [DATA_W-1:0]            PWDATA;
    logic [NUM_SLAVES*DATA_W-1:0] PRDATA;
    logic [NUM_SLAVES-1:0]        PREADY;
    logic [NUM_SLAVES-1:0]        PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master_mc.sv
// rtl/apb_master_mc.sv - valid/ready command to multi-slave APB bridge
// Address-decoded one-hot PSEL, PREADY wait states, PSLVERR/decode-miss/watchdog errors.
module apb_master_mc #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SLOT_LOG2  = 12,
    parameter int TIMEOUT    = 16
) (
    input  logic           PCLK,
    input  logic           PRESET,
    apb_master_mc_if.master bus
);
    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [NUM_SLAVES-1:0] psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]     paddr_q, paddr_d;
    logic [DATA_W-1:0]     pwdata_q, pwdata_d;
    logic [SEL_W-1:0]      slot_q, slot_d;
    logic [WD_W-1:0]       wdog_q, wdog_d;

    logic [ADDR_W-1:0]     addr_shift;
    logic                  in_range;
    logic                  hs;
    logic                  sel_ready;
    logic                  sel_err;
    logic [DATA_W-1:0]     sel_rdata;
    logic [WD_W-1:0]       wdog_inc;
    logic                  tmo;

    assign addr_shift = bus.cmd_addr >> SLOT_LOG2;
    assign in_range   = addr_shift < ADDR_W'(NUM_SLAVES);
    assign hs         = bus.cmd_valid && cmd_ready_q;
    assign sel_ready  = bus.PREADY[slot_q];
    assign sel_err    = bus.PSLVERR[slot_q];
    assign wdog_inc   = wdog_q + 1'b1;
    assign tmo        = (wdog_inc == WD_W'(TIMEOUT));

    // Only the latched slot's read data is ever looked at.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (slot_q == SEL_W'(i)) sel_rdata = bus.PRDATA[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            slot_q      <= '0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            slot_q      <= slot_d;
            wdog_q      <= wdog_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs && in_range) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (sel_ready || tmo) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Register next values; a decode miss answers from IDLE without touching the bus.
    always_comb begin
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        slot_d      = slot_q;
        wdog_d      = wdog_q;
        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (hs) begin
                    cmd_ready_d = 1'b0;
                    if (in_range) begin
                        psel_d   = NUM_SLAVES'(1) << addr_shift[SEL_W-1:0];
                        pwrite_d = bus.cmd_write;
                        paddr_d  = bus.cmd_addr;
                        pwdata_d = bus.cmd_wdata;
                        slot_d   = addr_shift[SEL_W-1:0];
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                wdog_d    = '0;
            end
            ACCESS: begin
                if (sel_ready || tmo) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    cmd_ready_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = sel_ready ? sel_err : 1'b1;
                    if (sel_ready && !sel_err && !pwrite_q) rsp_rdata_d = sel_rdata;
                end
                if (!sel_ready) wdog_d = wdog_inc;
            end
            default: ;
        endcase
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
endmodule

// File: tb/tb_apb_master_mc.sv
// tb/tb_apb_master_mc.sv - directed self-checking bench for apb_master_mc
module tb_apb_master_mc;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;

    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    always #5 PCLK = ~PCLK;

    apb_master_mc_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS)) bus ();

    apb_master_mc #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS), .SLOT_LOG2(12), .TIMEOUT(16)
    ) dut (
        .PCLK(PCLK),
        .PRESET(PRESET),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    logic [31:0] mem [NS];

    int          r_lat, r_acc, r_psel_cyc, r_pen_cyc, r_paddr_bad;
    logic [3:0]  r_psel_or;
    logic [31:0] r_rdata;
    logic        r_err, r_ready_rsp;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Issue one command and walk it to its response, acting as the addressed slave.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int waits, input logic slverr, input logic hang);
        int slot;
        logic [3:0] m;
        slot = int'(a >> 12);
        m = 4'(1) << slot;
        r_lat = -1; r_acc = 0; r_psel_cyc = 0; r_pen_cyc = 0; r_paddr_bad = 0;
        r_psel_or = '0; r_rdata = '0; r_err = 1'b0; r_ready_rsp = 1'b0;
        bus.PRDATA    = {mem[3], mem[2], mem[1], mem[0]};
        bus.PREADY    = hang ? ~m : 4'b0;
        bus.PSLVERR   = hang ? ~m : 4'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        for (int k = 0; k < 5 && !bus.cmd_ready; k++) tick();
        tick();
        bus.cmd_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (bus.rsp_valid) begin
                r_lat = n; r_rdata = bus.rsp_rdata; r_err = bus.rsp_err;
                r_ready_rsp = bus.cmd_ready;
                break;
            end
            if (bus.PSEL != 4'b0) r_psel_cyc++;
            r_psel_or = r_psel_or | bus.PSEL;
            if (bus.PENABLE) begin
                r_acc++;
                if (bus.PADDR !== a || bus.PWRITE !== w) r_paddr_bad++;
                if (!hang && r_acc == waits + 1) begin
                    bus.PREADY  = m;
                    bus.PSLVERR = slverr ? m : 4'b0;
                end
            end
            tick();
        end
        bus.PREADY = 4'b0; bus.PSLVERR = 4'b0;
        if (w && !slverr && !hang && slot < NS && r_lat > 0) mem[slot] = d;
    endtask

    int hs_t [4];
    int hs_n, rsp_n, rst_rsp;

    initial begin
        mem[0] = 32'h0; mem[1] = 32'h0; mem[2] = 32'hDEAD_BEEF; mem[3] = 32'hA5A5_A5A5;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.PRDATA = '0; bus.PREADY = '0; bus.PSLVERR = '0;
        #12;
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_psel",      bus.PSEL, 0);
        check("rst_penable",   bus.PENABLE, 0);
        check("rst_paddr",     bus.PADDR, 0);
        check("rst_rdata",     bus.rsp_rdata, 0);
        tick();
        PRESET = 1'b0;
        tick();

        xfer(1'b1, 32'h0, 32'h5, 0, 1'b0, 1'b0);
        check("t1_lat",      r_lat, 3);
        check("t1_psel_cyc", r_psel_cyc, 2);
        check("t1_psel",     r_psel_or, 4'b0001);
        check("t1_err",      r_err, 0);
        check("t1_ready",    r_ready_rsp, 1);

        xfer(1'b1, 32'h1004, 32'h2612_2023, 0, 1'b0, 1'b0);
        check("t2w_err", r_err, 0);
        check("t2w_pwdata", bus.PWDATA, 32'h2612_2023);
        xfer(1'b0, 32'h1004, 32'h0, 2, 1'b0, 1'b0);
        check("t2r_psel",  r_psel_or, 4'b0010);
        check("t2r_acc",   r_acc, 3);
        check("t2r_lat",   r_lat, 5);
        check("t2r_rdata", r_rdata, 32'h2612_2023);
        check("t2r_paddr", r_paddr_bad, 0);
        check("t2r_paddr_hold", bus.PADDR, 32'h1004);

        xfer(1'b0, 32'h3008, 32'h0, 0, 1'b1, 1'b0);
        check("t3_err",   r_err, 1);
        check("t3_rdata", r_rdata, 0);
        check("t3_psel",  r_psel_or, 4'b1000);

        xfer(1'b1, 32'h4000, 32'h1, 0, 1'b0, 1'b0);
        check("t4_psel",  r_psel_or, 0);
        check("t4_pen",   r_acc, 0);
        check("t4_lat",   r_lat, 1);
        check("t4_err",   r_err, 1);
        check("t4_ready", r_ready_rsp, 0);
        check("t4_paddr", bus.PADDR, 32'h3008);

        xfer(1'b0, 32'h2000, 32'h0, 0, 1'b0, 1'b1);
        check("t5_acc",   r_acc, 16);
        check("t5_lat",   r_lat, 18);
        check("t5_err",   r_err, 1);
        check("t5_rdata", r_rdata, 0);
        xfer(1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
        check("t5_next_err",   r_err, 0);
        check("t5_next_lat",   r_lat, 3);
        check("t5_next_rdata", r_rdata, 32'h5);

        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h8; bus.PREADY = 4'b0;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        check("t6_in_access", bus.PENABLE, 1);
        #2 PRESET = 1'b1;
        #1;
        check("t6_psel_async", bus.PSEL, 0);
        check("t6_pen_async",  bus.PENABLE, 0);
        check("t6_paddr_rst",  bus.PADDR, 0);
        check("t6_ready_rst",  bus.cmd_ready, 1);
        rst_rsp = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.rsp_valid) rst_rsp++;
        end
        PRESET = 1'b0;
        bus.PREADY = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            if (bus.rsp_valid) rst_rsp++;
            tick();
        end
        check("t6_no_rsp", rst_rsp, 0);

        hs_n = 0; rsp_n = 0;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 32'h10; bus.cmd_wdata = 32'h7;
        for (int t = 0; t < 10; t++) begin
            if (bus.cmd_ready && hs_n < 4) begin
                hs_t[hs_n] = t;
                hs_n++;
            end
            if (bus.rsp_valid) rsp_n++;
            tick();
        end
        bus.cmd_valid = 1'b0;
        check("t6_hs_count", hs_n, 4);
        check("t6_spacing",  hs_t[1] - hs_t[0], 3);
        check("t6_spacing2", hs_t[2] - hs_t[1], 3);
        check("t6_rsp_count", rsp_n, 3);
        for (int k = 0; k < 5; k++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
